// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one memory-mapped data bus between the core (master 0, fixed
// priority) and a secondary requester (master 1), and routes read responses back to the
// master that issued them. Defining ARB_LOCK_EN adds the m0_lock_i bus-lock input.
//
// state | meaning
// IDLE  | no bus access was granted last cycle
// RD0   | master 0 read was granted last cycle, response due now
// RD1   | master 1 read was granted last cycle, response due now
// WR    | a write was granted last cycle, no response
module data_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              m0_en_i,
  input  logic [3:0]        m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_data_o,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock_i,
`endif

  input  logic              m1_en_i,
  input  logic [3:0]        m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_data_o,

  output logic              bus_en_o,
  output logic [3:0]        bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic lock_active;
  logic force_m1;
  logic gnt0, gnt1;

`ifdef ARB_LOCK_EN
  assign lock_active = m0_lock_i;
`else
  assign lock_active = 1'b0;
`endif

  // Master 1 wins when master 0 is idle or once it has waited MAX_WAIT cycles.
  always_comb begin
    force_m1 = m1_en_i && (wait_cnt_q == MAX_WAIT_C);
    gnt1     = !lock_active && m1_en_i && (force_m1 || !m0_en_i);
    gnt0     = m0_en_i && !gnt1;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    bus_en_o   = 1'b0;
    bus_we_o   = '0;
    bus_addr_o = '0;
    bus_data_o = '0;
    if (gnt1) begin
      bus_en_o   = 1'b1;
      bus_we_o   = m1_we_i;
      bus_addr_o = m1_addr_i;
      bus_data_o = m1_data_i;
    end else if (gnt0) begin
      bus_en_o   = 1'b1;
      bus_we_o   = m0_we_i;
      bus_addr_o = m0_addr_i;
      bus_data_o = m0_data_i;
    end
  end

  // A lock freezes the count so the wait already served is not lost.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!lock_active) begin
      if (!m1_en_i || gnt1) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (gnt1) begin
      state_d = (m1_we_i == 4'd0) ? ST_RD1 : ST_WR;
    end else if (gnt0) begin
      state_d = (m0_we_i == 4'd0) ? ST_RD0 : ST_WR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    m0_rvalid_o = (state_q == ST_RD0);
    m1_rvalid_o = (state_q == ST_RD1);
    m0_data_o   = m0_rvalid_o ? bus_data_i : '0;
    m1_data_o   = m1_rvalid_o ? bus_data_i : '0;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed-vector bench for data_bus_arbiter; lock scenario is
// exercised only when ARB_LOCK_EN is defined.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_en_i, m1_en_i;
  logic [3:0]  m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        bus_en_o;
  logic [3:0]  bus_we_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
`ifdef ARB_LOCK_EN
  logic        m0_lock_i;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_en_i(m0_en_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o),
`ifdef ARB_LOCK_EN
    .m0_lock_i(m0_lock_i),
`endif
    .m1_en_i(m1_en_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o),
    .bus_en_o(bus_en_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_en_i = 1'b0; m0_we_i = 4'h0; m0_addr_i = '0; m0_data_i = '0;
    m1_en_i = 1'b0; m1_we_i = 4'h0; m1_addr_i = '0; m1_data_i = '0;
    bus_data_i = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m0_gnt"}, 32'(m0_gnt_o), 32'd0);
    check({tag, "_m1_gnt"}, 32'(m1_gnt_o), 32'd0);
    check({tag, "_bus_en"}, 32'(bus_en_o), 32'd0);
    check({tag, "_m0_rv"},  32'(m0_rvalid_o), 32'd0);
    check({tag, "_m1_rv"},  32'(m1_rvalid_o), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_wait;
    logic       exp_g1;
    int         m1_grants;

    idle_inputs();
    reset_n = 1'b0;
`ifdef ARB_LOCK_EN
    m0_lock_i = 1'b0;
`endif

    // Reset, then idle with non-zero request fields but no enables.
    repeat (3) next_cycle();
    settle();
    check_quiet("rst");
    next_cycle();
    reset_n = 1'b1;
    m0_addr_i = 32'h55; m0_data_i = 32'h1111; m0_we_i = 4'hF;
    m1_addr_i = 32'h66; m1_data_i = 32'h2222; m1_we_i = 4'h3;
    settle();
    for (int i = 0; i < 2; i++) begin
      check_quiet("idle");
      check("idle_bus_addr", bus_addr_o, 32'h0);
      check("idle_bus_we",   32'(bus_we_o), 32'h0);
      check("idle_bus_data", bus_data_o, 32'h0);
      check("idle_wait",     32'(dut.wait_cnt_q), 32'd0);
      next_cycle();
      settle();
    end

    // Single m0 read with response the following cycle.
    next_cycle();
    idle_inputs();
    m0_en_i = 1'b1; m0_addr_i = 32'h0000_1000;
    settle();
    check("rd0_gnt0",   32'(m0_gnt_o), 32'd1);
    check("rd0_gnt1",   32'(m1_gnt_o), 32'd0);
    check("rd0_bus_en", 32'(bus_en_o), 32'd1);
    check("rd0_addr",   bus_addr_o, 32'h0000_1000);
    check("rd0_we",     32'(bus_we_o), 32'h0);
    next_cycle();
    m0_en_i = 1'b0; bus_data_i = 32'hDEAD_BEEF;
    settle();
    check("rd0_rv0",  32'(m0_rvalid_o), 32'd1);
    check("rd0_data", m0_data_o, 32'hDEAD_BEEF);
    check("rd0_rv1",  32'(m1_rvalid_o), 32'd0);
    check("rd0_m1d",  m1_data_o, 32'h0);

    // m0 write contends with m1 read; m1 follows once m0 idles.
    next_cycle();
    idle_inputs();
    m0_en_i = 1'b1; m0_we_i = 4'hF; m0_addr_i = 32'h2000; m0_data_i = 32'h1122_3344;
    m1_en_i = 1'b1; m1_we_i = 4'h0; m1_addr_i = 32'h3000;
    settle();
    check("wr_gnt0",   32'(m0_gnt_o), 32'd1);
    check("wr_gnt1",   32'(m1_gnt_o), 32'd0);
    check("wr_bus_we", 32'(bus_we_o), 32'hF);
    check("wr_addr",   bus_addr_o, 32'h2000);
    check("wr_data",   bus_data_o, 32'h1122_3344);
    next_cycle();
    m0_en_i = 1'b0;
    settle();
    check("m1rd_gnt1", 32'(m1_gnt_o), 32'd1);
    check("m1rd_gnt0", 32'(m0_gnt_o), 32'd0);
    check("m1rd_addr", bus_addr_o, 32'h3000);
    check("wr_no_rv0", 32'(m0_rvalid_o), 32'd0);
    check("wr_no_rv1", 32'(m1_rvalid_o), 32'd0);
    next_cycle();
    m1_en_i = 1'b0; bus_data_i = 32'hCAFE_F00D;
    settle();
    check("m1rd_rv1",  32'(m1_rvalid_o), 32'd1);
    check("m1rd_data", m1_data_o, 32'hCAFE_F00D);
    check("m1rd_rv0",  32'(m0_rvalid_o), 32'd0);
    check("m1rd_m0d",  m0_data_o, 32'h0);
    check("m1rd_bus_en", 32'(bus_en_o), 32'd0);

    // Both masters saturate the bus: m1 gets one grant every MAX_WAIT+1 cycles.
    exp_wait = 8'd0;
    m1_grants = 0;
    for (int k = 0; k < 27; k++) begin
      next_cycle();
      idle_inputs();
      m0_en_i = 1'b1; m0_we_i = 4'hF; m0_addr_i = 32'h4000 + 32'(k);
      m1_en_i = 1'b1; m1_we_i = 4'hF; m1_addr_i = 32'h5000 + 32'(k);
      settle();
      exp_g1 = (exp_wait == 8'd8);
      check("stv_gnt1", 32'(m1_gnt_o), 32'(exp_g1));
      check("stv_gnt0", 32'(m0_gnt_o), 32'(!exp_g1));
      check("stv_wait", 32'(dut.wait_cnt_q), 32'(exp_wait));
      if (m1_gnt_o) m1_grants++;
      exp_wait = exp_g1 ? 8'd0 : exp_wait + 8'd1;
    end
    check("stv_m1_grants", 32'(m1_grants), 32'd3);
    next_cycle();
    idle_inputs();
    next_cycle();
    settle();
    check("stv_wait_clr", 32'(dut.wait_cnt_q), 32'd0);

    // Alternating single reads; each response must land on the issuing master.
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      idle_inputs();
      bus_data_i = 32'hA000_0000 + 32'(k);
      if (k < 8) begin
        if (k % 2 == 0) begin m0_en_i = 1'b1; m0_addr_i = 32'h100 + 32'(k); end
        else            begin m1_en_i = 1'b1; m1_addr_i = 32'h200 + 32'(k); end
      end
      settle();
      if (k < 8) begin
        check("alt_gnt0", 32'(m0_gnt_o), 32'(k % 2 == 0));
        check("alt_gnt1", 32'(m1_gnt_o), 32'(k % 2 == 1));
      end
      if (k > 0) begin
        check("alt_rv0", 32'(m0_rvalid_o), 32'((k - 1) % 2 == 0));
        check("alt_rv1", 32'(m1_rvalid_o), 32'((k - 1) % 2 == 1));
        check("alt_data", ((k - 1) % 2 == 0) ? m0_data_o : m1_data_o, 32'hA000_0000 + 32'(k));
      end
    end

`ifdef ARB_LOCK_EN
    // Build wait_cnt to 3, lock for 20 cycles, then unlock and expect a forced grant.
    exp_wait = 8'd0;
    for (int k = 0; k < 31; k++) begin
      next_cycle();
      idle_inputs();
      m0_en_i = 1'b1; m0_addr_i = 32'h6000;
      m1_en_i = 1'b1; m1_addr_i = 32'h7000;
      m0_lock_i = (k >= 3 && k < 23);
      settle();
      exp_g1 = !m0_lock_i && (exp_wait == 8'd8);
      check("lck_gnt1", 32'(m1_gnt_o), 32'(exp_g1));
      check("lck_wait", 32'(dut.wait_cnt_q), 32'(exp_wait));
      if (k == 28) check("lck_forced", 32'(m1_gnt_o), 32'd1);
      if (!m0_lock_i) exp_wait = exp_g1 ? 8'd0 : exp_wait + 8'd1;
    end
    m0_lock_i = 1'b0;
    next_cycle();
    idle_inputs();
`endif

    // Reset asserted while an m1 read response is due.
    next_cycle();
    idle_inputs();
    m1_en_i = 1'b1; m1_addr_i = 32'h400;
    settle();
    check("rst_m1_gnt", 32'(m1_gnt_o), 32'd1);
    next_cycle();
    m1_en_i = 1'b0; bus_data_i = 32'h1234_5678;
    reset_n = 1'b0;
    #1;
    check("rst_m1_rv",   32'(m1_rvalid_o), 32'd0);
    check("rst_m1_data", m1_data_o, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      check_quiet("post_rst");
      check("post_rst_m1d", m1_data_o, 32'h0);
      next_cycle();
      settle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
